// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the datapath memory responder.
package cpu_mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} mem_op_t;

    // True when no address bit at or above addr_w is set.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input int unsigned addr_w);
        return (addr >> addr_w) == '0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// MAR/MDR memory request bus between the datapath (master) and the responder (slave).
interface mem_responder_if;
    import cpu_mem_pkg::*;

    logic              Read;
    logic              Write;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] MDRdata;
    logic [WORD_W-1:0] Mdatain;
    logic              Ready;
    logic              err;
    logic              busy;

    modport master (
        output Read, Write, address, MDRdata,
        input  Mdatain, Ready, err, busy
    );

    modport slave (
        input  Read, Write, address, MDRdata,
        output Mdatain, Ready, err, busy
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port that holds between reads.
module mem_array
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Array contents survive clear; only the read register is reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: latches a request, waits WAIT_CYCLES, then
// completes it with a one-cycle Ready pulse (err flags bad op or out-of-range address).
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            clear,
    mem_responder_if.slave  bus
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    mem_state_t        r_state;
    mem_op_t           r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;

    logic              w_complete;
    logic              w_we;
    logic              w_re;
    logic [WORD_W-1:0] w_rdata;

    // clear on the completion edge suppresses the array access.
    assign w_complete = (r_state == ACCESS) && (r_cnt == '0) && !clear;
    assign w_we       = w_complete && (r_op == OP_WR);
    assign w_re       = w_complete && (r_op == OP_RD);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.Read || bus.Write) begin
                        r_addr  <= bus.address[ADDR_W-1:0];
                        r_wdata <= bus.MDRdata;
                        if ((bus.Read && bus.Write) || !addr_in_range(bus.address, ADDR_W)) begin
                            r_op <= OP_BAD;
                        end else begin
                            r_op <= bus.Read ? OP_RD : OP_WR;
                        end
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                        r_err   <= (r_op == OP_BAD);
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clock   (clock),
        .clear   (clear),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign bus.Mdatain = w_rdata;
    assign bus.Ready   = r_ready;
    assign bus.err     = r_err;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: randomized requests on a WAIT_CYCLES=2 responder checked against an
// array model, plus back-to-back timing on a WAIT_CYCLES=0 instance.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned WAIT_A = 2;
    localparam int unsigned DEPTH  = 2**ADDR_W;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] md;
    } exp_t;

    logic clock;
    logic clear;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_md;
    exp_t        sb_q [$];
    exp_t        mon_e;

    mem_responder_if ifa ();
    mem_responder_if ifb ();

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_A)
    ) dut_a (
        .clock (clock),
        .clear (clear),
        .bus   (ifa)
    );

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clock (clock),
        .clear (clear),
        .bus   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Ready on DUT A must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (ifa.Ready === 1'b1) begin
            check("pending_on_ready", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(mon_e.due));
                check("err", 32'(ifa.err), 32'(mon_e.err));
                check("mdatain", ifa.Mdatain, mon_e.md);
                check("busy_in_resp", 32'(ifa.busy), 32'd1);
            end
        end
    end

    // Issue one request on DUT A, predict its response, hold the strobe until Ready.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit perturb);
        exp_t e;
        int   k;
        bit   got;
        @(negedge clock);
        ifa.Read    = rd;
        ifa.Write   = wr;
        ifa.address = addr;
        ifa.MDRdata = data;
        k = cyc;
        e.due = k + WAIT_A + 2;
        if ((rd && wr) || ((addr >> ADDR_W) != 0)) begin
            e.err = 1'b1;
        end else if (rd) begin
            model_md = model_mem[addr % DEPTH];
            e.err = 1'b0;
        end else begin
            model_mem[addr % DEPTH] = data;
            e.err = 1'b0;
        end
        e.md = model_md;
        sb_q.push_back(e);
        if (perturb) begin
            @(negedge clock);
            ifa.address = $urandom;
            ifa.MDRdata = $urandom;
            ifa.Read    = 1'b1;
            ifa.Write   = 1'b1;
            @(negedge clock);
            ifa.Read  = rd;
            ifa.Write = wr;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (ifa.Ready === 1'b1) got = 1'b1;
        end
        if (!got) check("ready_timeout", 32'(got), 32'd1);
        ifa.Read  = 1'b0;
        ifa.Write = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
    endtask

    // Write whose completion edge coincides with clear: nothing may complete.
    task automatic clear_on_completion(input logic [31:0] addr);
        @(negedge clock);
        ifa.Write   = 1'b1;
        ifa.address = addr;
        ifa.MDRdata = $urandom;
        repeat (WAIT_A + 1) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("clr_ready", 32'(ifa.Ready), 32'd0);
        check("clr_mdatain", ifa.Mdatain, 32'd0);
        check("clr_busy", 32'(ifa.busy), 32'd0);
        check("clr_err", 32'(ifa.err), 32'd0);
        clear     = 1'b0;
        ifa.Write = 1'b0;
        model_md  = 32'd0;
    endtask

    task automatic b_write(input logic [31:0] addr, input logic [31:0] data);
        bit got;
        @(negedge clock);
        ifb.Write   = 1'b1;
        ifb.address = addr;
        ifb.MDRdata = data;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (ifb.Ready === 1'b1) got = 1'b1;
        end
        check("b_write_ready", 32'(got), 32'd1);
        check("b_write_err", 32'(ifb.err), 32'd0);
        ifb.Write = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d1;
        logic [31:0] d2;
        int          pulses;
        int          last;
        int          op;

        n_checks = 0;
        n_fail   = 0;
        model_md = 32'd0;
        clear    = 1'b1;
        {ifa.Read, ifa.Write, ifa.address, ifa.MDRdata} = '0;
        {ifb.Read, ifb.Write, ifb.address, ifb.MDRdata} = '0;
        repeat (3) @(negedge clock);
        check("rst_a_ready", 32'(ifa.Ready), 32'd0);
        check("rst_a_err", 32'(ifa.err), 32'd0);
        check("rst_a_busy", 32'(ifa.busy), 32'd0);
        check("rst_a_mdatain", ifa.Mdatain, 32'd0);
        check("rst_b_ready", 32'(ifb.Ready), 32'd0);
        check("rst_b_busy", 32'(ifb.busy), 32'd0);
        check("rst_b_mdatain", ifb.Mdatain, 32'd0);
        clear = 1'b0;

        // Give every word a known value so the model can predict any read.
        for (int i = 0; i < int'(DEPTH); i++) do_txn(1'b0, 1'b1, 32'(i), $urandom, 1'b0);

        do_txn(1'b0, 1'b1, 32'h5, 32'hDEAD_BEEF, 1'b0);
        do_txn(1'b1, 1'b0, 32'h5, $urandom, 1'b0);
        do_txn(1'b1, 1'b1, 32'h3, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, 32'h3, $urandom, 1'b0);
        do_txn(1'b0, 1'b1, 32'h0000_0200, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, 32'h0, $urandom, 1'b0);
        do_txn(1'b0, 1'b1, 32'h1FF, $urandom, 1'b0);
        do_txn(1'b1, 1'b0, 32'h1FF, $urandom, 1'b0);
        do_txn(1'b0, 1'b1, 32'h11, $urandom, 1'b1);
        do_txn(1'b1, 1'b0, 32'h11, $urandom, 1'b1);
        do_txn(1'b1, 1'b0, 32'h12, $urandom, 1'b0);
        clear_on_completion(32'h7);
        do_txn(1'b1, 1'b0, 32'h7, $urandom, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = int'($urandom_range(0, 9));
            a  = 32'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(ADDR_W, 31));
            if (op == 0) do_txn(1'b1, 1'b1, a, $urandom, 1'b0);
            else if (op < 5) do_txn(1'b1, 1'b0, a, $urandom, ($urandom_range(0, 7) == 0));
            else do_txn(1'b0, 1'b1, a, $urandom, ($urandom_range(0, 7) == 0));
        end

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clock);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        // Zero wait states with Read held: Ready every third cycle, alternating words.
        d1 = $urandom;
        d2 = $urandom;
        b_write(32'h1, d1);
        b_write(32'h2, d2);
        @(negedge clock);
        ifb.Read    = 1'b1;
        ifb.address = 32'h1;
        pulses = 0;
        last   = 0;
        for (int i = 0; i < 40 && pulses < 6; i++) begin
            @(negedge clock);
            if (ifb.Ready === 1'b1) begin
                check("b_mdatain", ifb.Mdatain, (pulses % 2 == 0) ? d1 : d2);
                if (pulses > 0) check("b_period", 32'(cyc - last), 32'd3);
                last = cyc;
                pulses++;
                ifb.address = (pulses % 2 == 0) ? 32'h1 : 32'h2;
            end
        end
        ifb.Read = 1'b0;
        check("b_pulse_count", 32'(pulses), 32'd6);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
